// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the rv32 memory responder slice.
//   mem_rsp_t       : one response beat (valid, err, rdata) carried down the
//                     response delay line. err stays 0 when RV32_MEM_ERR_EN
//                     is not defined.
//   MEM_MAX_LATENCY : largest supported READ_LATENCY.
package rv32_pkg;

   localparam int unsigned MEM_MAX_LATENCY = 8;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } mem_rsp_t;

endpackage

// File: rtl/rv32_mem_rsp_pipe.sv
// rv32_mem_rsp_pipe: fixed-length delay line of mem_rsp_t beats.
//   clk_i   in   clock, rising edge
//   rst_ni  in   async active-low reset; flushes every stage
//   rsp_i   in   beat captured on each clock edge
//   rsp_o   out  beat captured LATENCY edges earlier (registered)
module rv32_mem_rsp_pipe
   import rv32_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  mem_rsp_t rsp_i,
   output mem_rsp_t rsp_o
);

   mem_rsp_t stage_q [LATENCY];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= rsp_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign rsp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder: responder end of the req/gnt/rvalid memory bus.
// Word-addressed SRAM with byte-enable writes and fixed-latency in-order
// responses; an outstanding-request limit drives gnt_o.
//   clk_i, rst_ni        clock / async active-low reset
//   req_i, gnt_o         request handshake (accept = req_i & gnt_o)
//   addr_i, we_i, be_i,  byte address, write flag, byte enables, write data
//   wdata_i
//   rvalid_o, rdata_o    registered response, READ_LATENCY cycles after accept
//   err_o                out-of-range flag, present only with RV32_MEM_ERR_EN
// Optional feature macro: RV32_MEM_ERR_EN (range checking and err_o).
module rv32_mem_responder
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS     = 1024,
   parameter int unsigned READ_LATENCY    = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BASE_ADDR       = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
`ifdef RV32_MEM_ERR_EN
   output logic [31:0] rdata_o,
   output logic        err_o
`else
   output logic [31:0] rdata_o
`endif
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [31:0]   offs;
   logic [AW-1:0] idx;
   logic          accept;
   logic          in_range;
   logic          wr_en;
   mem_rsp_t      rsp_d, rsp_q;
   logic          unused_bits;

   assign offs = addr_i - BASE_ADDR;
   assign idx  = offs[AW+1:2];

`ifdef RV32_MEM_ERR_EN
   // Underflow of addr_i - BASE_ADDR wraps high, so one check covers both ends.
   assign in_range    = ~|offs[31:AW+2];
   assign unused_bits = ^offs[1:0];
   assign err_o       = rsp_q.err;
`else
   assign in_range    = 1'b1;
   assign unused_bits = ^{offs[31:AW+2], offs[1:0], rsp_q.err};
`endif

   // Grant depends only on registered state: no req_i -> gnt_o path, and a
   // response leaving this cycle does not free a slot until the next one.
   assign gnt_o  = rst_ni & (32'(outstanding_q) < MAX_OUTSTANDING);
   assign accept = req_i & gnt_o;
   assign wr_en  = accept & we_i & in_range;

   // Array is not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Read data is captured into the delay line on the accept edge, so later
   // writes cannot disturb an in-flight response.
   always_comb begin
      rsp_d = '0;
      if (accept) begin
         rsp_d.valid = 1'b1;
         rsp_d.err   = ~in_range;
         if (!we_i && in_range) begin
            rsp_d.rdata = mem_q[idx];
         end
      end
   end

   rv32_mem_rsp_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_rsp_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .rsp_i  (rsp_d),
      .rsp_o  (rsp_q)
   );

   assign rvalid_o = rsp_q.valid;
   assign rdata_o  = rsp_q.rdata;

   always_comb begin
      outstanding_d = outstanding_q;
      if (accept && !rsp_q.valid) begin
         outstanding_d = outstanding_q + CW'(1);
      end else if (!accept && rsp_q.valid) begin
         outstanding_d = outstanding_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: tb/tb_rv32_mem_responder.sv
module tb_rv32_mem_responder;

   localparam int unsigned LAT   = 3;
   localparam int unsigned MAXO  = 2;
   localparam int unsigned DEPTH = 1024;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = '0;
   logic [3:0]  be    = '0;
   logic [31:0] wdata = '0;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   always #5 clk = ~clk;

   rv32_mem_responder #(
      .DEPTH_WORDS     (DEPTH),
      .READ_LATENCY    (LAT),
      .MAX_OUTSTANDING (MAXO),
      .BASE_ADDR       (32'h0)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req),
      .gnt_o    (gnt),
      .addr_i   (addr),
      .we_i     (we),
      .be_i     (be),
      .wdata_i  (wdata),
      .rvalid_o (rvalid),
`ifdef RV32_MEM_ERR_EN
      .rdata_o  (rdata),
      .err_o    (err)
`else
      .rdata_o  (rdata)
`endif
   );

`ifndef RV32_MEM_ERR_EN
   assign err = 1'b0;
`endif

   typedef struct {
      int unsigned due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] shadow [DEPTH];
   int unsigned cyc     = 0;
   int unsigned mdl_out = 0;
   int unsigned total   = 0;
   int unsigned bad     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s (cycle %0d): got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // One bus cycle, entered at a falling edge: drive, sample just before the
   // rising edge, advance the reference model, step to the next falling edge.
   task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, output logic acc);
      logic       eg, erv, inr;
      logic [9:0] ix;
      exp_t       e;
      req = r; we = w; addr = a; be = b; wdata = d;
      if (!rst_n) begin
         sb.delete();
         mdl_out = 0;
      end
      #4;
      eg  = rst_n && (mdl_out < MAXO);
      erv = rst_n && (sb.size() > 0) && (sb[0].due == cyc);
      check("gnt", gnt, eg);
      check("rvalid", rvalid, erv);
      if ((erv || rvalid) && sb.size() > 0) begin
         e = sb.pop_front();
         check("rdata", rdata, e.data);
         check("err", err, e.err);
      end
      acc = r && eg;
      if (acc) begin
`ifdef RV32_MEM_ERR_EN
         inr = (a < 32'(4 * DEPTH));
`else
         inr = 1'b1;
`endif
         ix     = a[11:2];
         e.due  = cyc + LAT;
         e.err  = !inr;
         e.data = '0;
         if (w) begin
            if (inr) begin
               for (int k = 0; k < 4; k++) begin
                  if (b[k]) shadow[ix][8*k +: 8] = d[8*k +: 8];
               end
            end
         end else if (inr) begin
            e.data = shadow[ix];
         end
         sb.push_back(e);
         mdl_out++;
      end
      if (erv) mdl_out--;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int unsigned n);
      logic acc;
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, acc);
   endtask

   // Hold the request until granted, bounded.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
      logic acc;
      acc = 1'b0;
      for (int unsigned t = 0; t < 20 && !acc; t++) cycle(1'b1, w, a, b, d, acc);
      if (!acc) check("xfer_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int unsigned t = 0; t < 30 && sb.size() > 0; t++) idle(1);
      if (sb.size() > 0) check("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      logic acc;
      @(negedge clk);

      // Reset with a request pending, then release.
      cycle(1'b1, 1'b0, 32'h10, '0, '0, acc);
      cycle(1'b1, 1'b0, 32'h10, '0, '0, acc);
      rst_n = 1'b1;
      idle(1);

      // Full write then read-after-write on the same word.
      xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      xfer(1'b0, 32'h10, 4'h0, '0);
      drain();

      // Partial write, then a be=0 no-op write.
      xfer(1'b1, 32'h10, 4'b0001, 32'h0000_00AA);
      xfer(1'b0, 32'h10, 4'h0, '0);
      xfer(1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF);
      xfer(1'b0, 32'h13, 4'h0, '0);
      drain();

      // In-flight read must keep the pre-write value.
      xfer(1'b0, 32'h10, 4'h0, '0);
      xfer(1'b1, 32'h10, 4'hF, 32'h1234_5678);
      xfer(1'b0, 32'h10, 4'h0, '0);
      drain();

      // Back-to-back reads under the outstanding limit, req held high.
      for (int unsigned i = 0; i < 8; i++) xfer(1'b1, 32'h100 + 4*i, 4'hF, 32'hA500_0000 + i);
      for (int unsigned i = 0; i < 8; i++) xfer(1'b0, 32'h100 + 4*i, 4'h0, '0);
      drain();

      // Reset with two reads in flight drops them.
      xfer(1'b0, 32'h100, 4'h0, '0);
      xfer(1'b0, 32'h104, 4'h0, '0);
      rst_n = 1'b0;
      cycle(1'b1, 1'b0, 32'h100, '0, '0, acc);
      rst_n = 1'b1;
      idle(6);
      xfer(1'b0, 32'h104, 4'h0, '0);
      drain();

      // Range boundary: 0x1000 is out of range with the error feature,
      // otherwise it aliases word 0.
      xfer(1'b1, 32'h0, 4'hF, 32'h0BAD_F00D);
      xfer(1'b1, 32'hFFC, 4'hF, 32'hCAFE_0FFC);
      drain();
      xfer(1'b1, 32'h1000, 4'hF, 32'h5555_5555);
      xfer(1'b0, 32'h0, 4'h0, '0);
      xfer(1'b0, 32'hFFC, 4'h0, '0);
      xfer(1'b0, 32'h2000, 4'h0, '0);
      drain();

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
